column_buffer_loader: RTL and testbench

COLUMN_BUFFER_LOADER -- requirements
Module: column_buffer_loader

---
 rtl/column_buffer_loader.sv | 132 +++++++++++++
 tb/tb_column_buffer_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_buffer_loader.sv
// column_buffer_loader: double-buffered per-column frame loader; fetches a frame from memory on v_sync,
// acknowledges it through a flag word and swaps it into the display buffer at the following frame start.
module column_buffer_loader #(
    parameter int                COLS       = 320,
    parameter int                CHANNELS   = 2,
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BANK0_BASE = 16'hF000,
    parameter logic [ADDR_W-1:0] BANK1_BASE = 16'hF800,
    parameter logic [ADDR_W-1:0] CH_STRIDE  = 16'h0200,
    parameter logic [ADDR_W-1:0] FLAG_ADDR  = 16'hFFFF,
    parameter int                CW         = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       v_sync,
    output logic                       rd_req,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_valid,
    input  logic [DATA_W-1:0]          rd_data,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          write_address,
    output logic [DATA_W-1:0]          write_data,
    input  logic [CW-1:0]              col_index,
    output logic [CHANNELS*DATA_W-1:0] col_data,
    output logic                       busy,
    output logic                       frame_loaded,
    output logic                       overrun
);
    localparam int CHW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, FLAG_REQ, FLAG_WAIT, DECODE, LOAD_REQ, LOAD_WAIT, ACK_WRITE} state_t;

    state_t                     r_state, w_next;
    logic                       r_vs_prev, r_active, r_swap_pending, r_overrun;
    logic [DATA_W-1:0]          r_flags;
    logic [CW-1:0]              r_col;
    logic [CHW-1:0]             r_ch;
    logic [DATA_W-1:0]          r_mem [2][COLS][CHANNELS];
    logic [CHANNELS*DATA_W-1:0] r_col_data, w_rd_col;
    logic                       w_frame_start, w_last_ch, w_last;
    logic [ADDR_W-1:0]          w_base, w_load_addr;

    assign w_frame_start = r_vs_prev & ~v_sync;
    assign w_last_ch     = 32'(r_ch) == CHANNELS - 1;
    assign w_last        = w_last_ch && (32'(r_col) == COLS - 1);
    assign w_base        = r_flags[1] ? BANK1_BASE : BANK0_BASE;
    assign w_load_addr   = w_base + ADDR_W'(r_ch) * CH_STRIDE + ADDR_W'(r_col);
    assign busy          = r_state != IDLE;
    assign col_data      = r_col_data;
    assign overrun       = r_overrun;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        rd_req        = 1'b0;
        rd_addr       = '0;
        write_enable  = 1'b0;
        write_address = '0;
        write_data    = '0;
        frame_loaded  = 1'b0;
        case (r_state)
            IDLE:      w_next = w_frame_start ? FLAG_REQ : IDLE;
            FLAG_REQ:  begin
                rd_req  = 1'b1;
                rd_addr = FLAG_ADDR;
                w_next  = FLAG_WAIT;
            end
            FLAG_WAIT: w_next = rd_valid ? DECODE : FLAG_WAIT;
            DECODE:    w_next = r_flags[0] ? IDLE : LOAD_REQ;
            LOAD_REQ:  begin
                rd_req  = 1'b1;
                rd_addr = w_load_addr;
                w_next  = LOAD_WAIT;
            end
            LOAD_WAIT: w_next = rd_valid ? (w_last ? ACK_WRITE : LOAD_REQ) : LOAD_WAIT;
            ACK_WRITE: begin
                write_enable  = 1'b1;
                write_address = FLAG_ADDR;
                write_data    = r_flags | DATA_W'(1);
                frame_loaded  = 1'b1;
                w_next        = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_vs_prev      <= 1'b1;
            r_active       <= 1'b0;
            r_swap_pending <= 1'b0;
            r_overrun      <= 1'b0;
            r_flags        <= '0;
            r_col          <= '0;
            r_ch           <= '0;
            r_col_data     <= '0;
        end else begin
            r_vs_prev  <= v_sync;
            r_col_data <= (32'(col_index) < COLS) ? w_rd_col : '0;
            if (r_state == FLAG_WAIT && rd_valid) r_flags <= rd_data;
            if (r_state == DECODE) begin
                r_col <= '0;
                r_ch  <= '0;
            end
            if (r_state == LOAD_WAIT && rd_valid) begin
                r_ch  <= w_last_ch ? '0 : r_ch + 1'b1;
                r_col <= w_last_ch ? r_col + 1'b1 : r_col;
            end
            if (w_frame_start && r_state != IDLE) r_overrun <= 1'b1;
            // a completed load waits for the next frame start before becoming visible
            if (r_state == ACK_WRITE) r_swap_pending <= 1'b1;
            else if (w_frame_start && r_swap_pending) begin
                r_swap_pending <= 1'b0;
                r_active       <= ~r_active;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD_WAIT && rd_valid) r_mem[~r_active][r_col][r_ch] <= rd_data;
    end

    always_comb begin
        w_rd_col = '0;
        for (int c = 0; c < CHANNELS; c++) w_rd_col[c*DATA_W +: DATA_W] = r_mem[r_active][col_index][c];
    end
endmodule

// File: tb/tb_column_buffer_loader.sv
// tb_column_buffer_loader: directed frames against a transaction-level model of the loader,
// memory responder with configurable latency, per-cycle checks plus literal expectations.
module tb_column_buffer_loader;
    localparam int COLS = 320;
    localparam int CH   = 2;
    localparam int NW   = COLS * CH;

    logic        clk = 1'b0;
    logic        clr, v_sync, rd_req, rd_valid, write_enable, busy, frame_loaded, overrun;
    logic [15:0] rd_addr, rd_data, write_address, write_data;
    logic [8:0]  col_index;
    logic [31:0] col_data;

    always #5 clk = ~clk;

    column_buffer_loader dut (
        .clk(clk), .clr(clr), .v_sync(v_sync),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .col_index(col_index), .col_data(col_data),
        .busy(busy), .frame_loaded(frame_loaded), .overrun(overrun)
    );

    int          checks = 0, errors = 0;
    logic [15:0] mem [65536];
    logic [15:0] m_disp [NW];
    logic [15:0] m_shadow [NW];
    logic [15:0] m_flags, paddr;
    logic [31:0] exp_cd;
    bit          m_busy, m_flag_known, m_skip, m_swap, m_disp_valid, m_vs_prev, m_overrun, exp_known;
    bit          pend, spur_req, fs, busy0, ok;
    int          m_nreq, m_got, cnt, pidx, ci, lat_max;
    int          n_reads, n_writes, n_fl;
    logic [15:0] obs_addr [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input int n, input logic [15:0] flags);
        int k;
        if (n == 0) return 16'hFFFF;
        k = n - 1;
        return (flags[1] ? 16'hF800 : 16'hF000) + 16'(k % CH) * 16'h0200 + 16'(k / CH);
    endfunction

    // model, checker and memory responder; everything evaluated mid-cycle
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (clr) begin
                chk("reset_outputs", |{rd_req, rd_addr, write_enable, write_address, write_data,
                                      col_data, busy, frame_loaded, overrun}, 0);
                rd_valid     = 1'b0;
                pend         = 0;
                m_busy       = 0;
                m_overrun    = 0;
                m_swap       = 0;
                m_disp_valid = 0;
                m_vs_prev    = 1;
                exp_cd       = '0;
                exp_known    = 1;
            end else begin
                fs    = m_vs_prev && !v_sync;
                busy0 = m_busy;
                if (exp_known) chk("col_data", col_data, exp_cd);
                chk("overrun", overrun, m_overrun);
                if (rd_req || write_enable) chk("busy", busy, 1);
                if (rd_req) begin
                    n_reads++;
                    obs_addr.push_back(rd_addr);
                    ok = m_busy && !pend && (m_nreq == 0 || (m_flag_known && !m_skip && m_nreq <= NW));
                    chk("rd_allowed", ok, 1);
                    chk("rd_addr", rd_addr, exp_addr(m_nreq, m_flags));
                end
                if (write_enable) begin
                    n_writes++;
                    chk("wr_allowed", m_busy && m_flag_known && !m_skip && m_got == NW, 1);
                    chk("wr_addr", write_address, 16'hFFFF);
                    chk("wr_data", write_data, m_flags | 16'h0001);
                    mem[write_address] = write_data;
                    m_busy = 0;
                    m_swap = 1;
                end
                n_fl += int'(frame_loaded);
                rd_valid = 1'b0;
                if (pend) begin
                    if (cnt == 1) begin
                        rd_valid = 1'b1;
                        rd_data  = mem[paddr];
                        pend     = 0;
                        if (pidx == 0) begin
                            m_flags      = rd_data;
                            m_flag_known = 1;
                            m_skip       = rd_data[0];
                            if (m_skip) m_busy = 0;
                        end else if (pidx <= NW) begin
                            m_shadow[pidx-1] = rd_data;
                            m_got++;
                        end
                    end else cnt--;
                end else if (spur_req) begin
                    rd_valid = 1'b1;
                    rd_data  = 16'hBEEF;
                    spur_req = 0;
                end
                if (rd_req) begin
                    pend  = 1;
                    cnt   = int'($urandom_range(lat_max, 1));
                    paddr = rd_addr;
                    pidx  = m_nreq;
                    m_nreq++;
                end
                ci = int'(col_index);
                if (ci >= COLS) begin
                    exp_cd    = '0;
                    exp_known = 1;
                end else begin
                    exp_cd    = {m_disp[ci*CH+1], m_disp[ci*CH]};
                    exp_known = m_disp_valid;
                end
                if (fs) begin
                    if (busy0) m_overrun = 1;
                    else begin
                        if (m_swap) begin
                            m_disp       = m_shadow;
                            m_disp_valid = 1;
                            m_swap       = 0;
                        end
                        m_busy       = 1;
                        m_nreq       = 0;
                        m_got        = 0;
                        m_flag_known = 0;
                        m_skip       = 0;
                    end
                end
                m_vs_prev = v_sync;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start();
        v_sync = 1'b0;
        tick(1);
        v_sync = 1'b1;
        tick(1);
    endtask

    task automatic clear_counts();
        n_reads  = 0;
        n_writes = 0;
        n_fl     = 0;
        obs_addr.delete();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20000 && m_busy; i++) tick(1);
        chk({name, "_done"}, m_busy, 0);
        tick(5);
    endtask

    task automatic show_col(input int c, input logic [31:0] exp, input string name);
        col_index = 9'(c);
        tick(2);
        chk(name, col_data, exp);
    endtask

    initial begin
        clr       = 1'b1;
        v_sync    = 1'b1;
        col_index = '0;
        spur_req  = 0;
        lat_max   = 1;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a);
        tick(3);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_col_data", col_data, 0);
        chk("rst_write_enable", write_enable, 0);
        clr = 1'b0;
        tick(2);

        // frame A: bank 0, latency 1
        mem[16'hFFFF] = 16'h0000;
        clear_counts();
        frame_start();
        wait_idle("A");
        chk("A_reads", n_reads, 641);
        chk("A_writes", n_writes, 1);
        chk("A_frame_loaded", n_fl, 1);
        chk("A_rd0", obs_addr[0], 16'hFFFF);
        chk("A_rd1", obs_addr[1], 16'hF000);
        chk("A_rd2", obs_addr[2], 16'hF200);
        chk("A_rd3", obs_addr[3], 16'hF001);
        chk("A_rd_last", obs_addr[640], 16'hF33F);
        chk("A_flag_word", mem[16'hFFFF], 16'h0001);
        chk("A_busy", busy, 0);

        // frame B: bank 1; A becomes visible at this edge
        mem[16'hFFFF] = 16'h0002;
        clear_counts();
        frame_start();
        show_col(5, 32'hF205F005, "B_col5_A");
        show_col(319, 32'hF33FF13F, "B_col319_A");
        show_col(320, 32'h0, "B_col320");
        show_col(511, 32'h0, "B_col511");
        wait_idle("B");
        chk("B_reads", n_reads, 641);
        chk("B_rd1", obs_addr[1], 16'hF800);
        chk("B_rd2", obs_addr[2], 16'hFA00);
        chk("B_flag_word", mem[16'hFFFF], 16'h0003);
        show_col(5, 32'hF205F005, "B_no_early_swap");

        // frame C: no-new-frame flag, B swaps in
        mem[16'hFFFF] = 16'h0001;
        clear_counts();
        frame_start();
        wait_idle("C");
        chk("C_reads", n_reads, 1);
        chk("C_writes", n_writes, 0);
        chk("C_rd0", obs_addr[0], 16'hFFFF);
        chk("C_frame_loaded", n_fl, 0);
        show_col(5, 32'hFA05F805, "C_col5_B");
        clear_counts();
        frame_start();
        wait_idle("C2");
        show_col(5, 32'hFA05F805, "C2_no_swap");
        chk("C2_writes", n_writes, 0);

        spur_req = 1;
        tick(4);
        chk("spur_busy", busy, 0);

        // frame D: new bank-0 data, random latency, overrun mid-load
        for (int a = 16'hF000; a < 16'hF400; a++) mem[a] = 16'(a) ^ 16'h3C3C;
        mem[16'hFFFF] = 16'h0000;
        lat_max = 7;
        clear_counts();
        frame_start();
        for (int i = 0; i < 5000 && n_reads < 100; i++) tick(1);
        chk("D_progress", n_reads >= 100, 1);
        frame_start();
        tick(2);
        chk("D_overrun", overrun, 1);
        wait_idle("D");
        chk("D_reads", n_reads, 641);
        chk("D_writes", n_writes, 1);
        chk("D_overrun_sticky", overrun, 1);
        show_col(7, 32'hFA07F807, "D_col7_B");
        frame_start();
        show_col(7, 32'hCE3BCC3B, "D_col7_D");
        wait_idle("D_skip");

        // frame E: reset mid-load, then a clean restart
        mem[16'hFFFF] = 16'h0000;
        clear_counts();
        frame_start();
        for (int i = 0; i < 5000 && n_reads < 30; i++) tick(1);
        for (int i = 0; i < 20 && rd_req; i++) tick(1);
        chk("E_in_wait", busy && !rd_req, 1);
        clr = 1'b1;
        #1;
        chk("E_clr_rd_req", rd_req, 0);
        chk("E_clr_busy", busy, 0);
        chk("E_clr_overrun", overrun, 0);
        chk("E_clr_col_data", col_data, 0);
        chk("E_clr_wr", {write_enable, frame_loaded}, 0);
        tick(2);
        clr = 1'b0;
        clear_counts();
        tick(20);
        chk("E_no_write", n_writes, 0);
        chk("E_idle", busy, 0);
        lat_max = 1;
        frame_start();
        wait_idle("E2");
        chk("E2_rd0", obs_addr[0], 16'hFFFF);
        chk("E2_reads", n_reads, 641);
        chk("E2_writes", n_writes, 1);
        frame_start();
        show_col(7, 32'hCE3BCC3B, "E2_col7");
        show_col(0, 32'hCE3CCC3C, "E2_col0");
        wait_idle("E3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
